// File: rtl/vc_test_rand_delay_sink_pkg.sv
// Shared types and helpers for the random-delay test sink.
package vc_test_rand_delay_sink_pkg;

  localparam int unsigned c_state_sz = 1;
  localparam int unsigned c_cnt_w    = 32;
  localparam int unsigned c_lfsr_w   = 32;

  typedef enum logic [c_state_sz-1:0] {
    c_state_idle  = 1'b0,
    c_state_delay = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] v);
    return (v == '1) ? v : v + c_cnt_w'(1);
  endfunction

endpackage

// File: rtl/vc_test_rand_delay_sink_if.sv
// Val/rdy message stream between a producer (master) and a consumer (slave).
interface vc_test_rand_delay_sink_if #(
  parameter int unsigned p_msg_nbits = 1
);
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/vc_test_rand_delay_sink_gen.sv
// Registered pseudo-random stall length in [0, max_delay-1]; 0 when max_delay is 0.
module vc_test_rand_delay_sink_gen
  import vc_test_rand_delay_sink_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [c_cnt_w-1:0] max_delay,
  output logic [c_cnt_w-1:0] rand_num
);

  localparam logic [c_lfsr_w-1:0] c_lfsr_taps = 32'h8020_0003;
  localparam logic [c_lfsr_w-1:0] c_lfsr_seed = 32'hACE1_2468;

  logic [c_lfsr_w-1:0] lfsr_q, lfsr_d;
  logic [c_cnt_w-1:0]  rand_num_q, rand_num_d;

  // Galois LFSR step and modulo reduction of the current state.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[c_lfsr_w-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ c_lfsr_taps;
    end
    rand_num_d = '0;
    if (max_delay != '0) begin
      rand_num_d = c_cnt_w'(lfsr_q % max_delay);
    end
  end

  // Generator state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= c_lfsr_seed;
      rand_num_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      rand_num_q <= rand_num_d;
    end
  end

  assign rand_num = rand_num_q;

endmodule

// File: rtl/vc_test_rand_delay_sink.sv
// Test-harness stream sink: throttles ready with random stalls and checks
// every accepted message against a preloaded expected-message table.
module vc_test_rand_delay_sink
  import vc_test_rand_delay_sink_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 1,
  parameter int unsigned p_num_msgs  = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [c_cnt_w-1:0]          max_delay,
  input  logic [c_cnt_w-1:0]          num_msgs,
  vc_test_rand_delay_sink_if.slave    in_if,
  output logic                        done,
  output logic [c_cnt_w-1:0]          num_failed,
  output logic                        error
);

  localparam int unsigned c_idx_w = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

  // Expected-message table; not touched by reset, filled through load_msg.
  logic [p_msg_nbits-1:0] m [p_num_msgs];

  task automatic load_msg(input logic [c_idx_w-1:0] idx, input logic [p_msg_nbits-1:0] msg);
    m[idx] = msg;
  endtask

  state_e             state_q, state_d;
  logic [c_cnt_w-1:0] delay_q, delay_d;
  logic [c_cnt_w-1:0] index_q, index_d;
  logic [c_cnt_w-1:0] num_failed_q, num_failed_d;
  logic               error_q, error_d;
  logic [c_cnt_w-1:0] rand_num;
  logic               rdy_c;
  logic               fire_c;
  logic               mismatch_c;
  logic [p_msg_nbits-1:0] exp_msg_c;

  vc_test_rand_delay_sink_gen u_gen (
    .clk       (clk),
    .reset     (reset),
    .max_delay (max_delay),
    .rand_num  (rand_num)
  );

  assign done       = (index_q == num_msgs);
  assign exp_msg_c  = m[index_q[c_idx_w-1:0]];
  assign mismatch_c = (in_if.msg !== exp_msg_c);
  assign rdy_c      = !done && ((state_q == c_state_idle) ? (rand_num == '0) : (delay_q == '0));
  assign fire_c     = in_if.val && rdy_c;
  assign in_if.rdy  = rdy_c;

  // Next-state: stall countdown, table index and failure bookkeeping.
  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    index_d      = index_q;
    num_failed_d = num_failed_q;
    error_d      = 1'b0;
    case (state_q)
      c_state_idle: begin
        if (in_if.val && !done && (rand_num != '0)) begin
          state_d = c_state_delay;
          delay_d = rand_num - c_cnt_w'(1);
        end
      end
      c_state_delay: begin
        if (delay_q != '0) begin
          delay_d = delay_q - c_cnt_w'(1);
        end
        if (fire_c) begin
          state_d = c_state_idle;
        end
      end
      default: state_d = c_state_idle;
    endcase
    if (fire_c) begin
      index_d = index_q + c_cnt_w'(1);
      if (mismatch_c) begin
        num_failed_d = sat_inc(num_failed_q);
        error_d      = 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= c_state_idle;
      delay_q      <= '0;
      index_q      <= '0;
      num_failed_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      index_q      <= index_d;
      num_failed_q <= num_failed_d;
      error_q      <= error_d;
    end
  end

  assign num_failed = num_failed_q;
  assign error      = error_q;

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// Directed bench for the random-delay test sink.
module tb_vc_test_rand_delay_sink;
  import vc_test_rand_delay_sink_pkg::*;

  localparam int unsigned c_nbits = 8;
  localparam int unsigned c_depth = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] max_delay = 32'd0;
  logic [31:0] num_msgs = 32'd0;
  logic        done;
  logic [31:0] num_failed;
  logic        error;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int rdy_viol = 0;

  vc_test_rand_delay_sink_if #(.p_msg_nbits(c_nbits)) ifc ();

  vc_test_rand_delay_sink #(.p_msg_nbits(c_nbits), .p_num_msgs(c_depth)) dut (
    .clk        (clk),
    .reset      (reset),
    .max_delay  (max_delay),
    .num_msgs   (num_msgs),
    .in_if      (ifc),
    .done       (done),
    .num_failed (num_failed),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Background observation of error pulses and ready-during-stall.
  always @(negedge clk) begin
    if (error === 1'b1) err_pulses++;
    if (dut.state_q == c_state_delay && dut.delay_q != 32'd0 && ifc.rdy === 1'b1) rdy_viol++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    ifc.val = 1'b0;
    ifc.msg = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    dut.load_msg(4'd0, a);
    dut.load_msg(4'd1, b);
    dut.load_msg(4'd2, c);
  endtask

  // Present one message and hold until accepted; returns cycles stalled.
  task automatic send(input logic [7:0] msg, input string name, output int stall);
    bit got;
    stall = 0;
    got = 1'b0;
    ifc.val = 1'b1;
    ifc.msg = msg;
    while (!got && stall < 64) begin
      @(negedge clk);
      if (ifc.rdy === 1'b1) begin
        got = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        stall++;
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: stalled %0d cycles, required acceptance", name, stall);
    end
  endtask

  task automatic test_reset();
    max_delay = 32'd0;
    num_msgs = 32'd0;
    reset = 1'b1;
    ifc.val = 1'b0;
    ifc.msg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done_zero: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL reset_num_failed: got %0d expected 0", num_failed); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
    num_msgs = 32'd3;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done_three: got %b expected 0", done); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ifc.rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b expected 1", ifc.rdy); end
    checks++; if (dut.index_q !== 32'd0) begin failures++; $display("FAIL reset_index: got %0d expected 0", dut.index_q); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_delay();
    int s;
    int e0;
    max_delay = 32'd0;
    num_msgs = 32'd3;
    load3(8'h11, 8'h22, 8'h33);
    do_reset();
    e0 = err_pulses;
    send(8'h11, "zd_m0", s);
    checks++; if (s != 0) begin failures++; $display("FAIL zd_stall0: got %0d expected 0", s); end
    send(8'h22, "zd_m1", s);
    checks++; if (s != 0) begin failures++; $display("FAIL zd_stall1: got %0d expected 0", s); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zd_done_early: got %b expected 0", done); end
    send(8'h33, "zd_m2", s);
    checks++; if (s != 0) begin failures++; $display("FAIL zd_stall2: got %0d expected 0", s); end
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zd_done: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL zd_num_failed: got %0d expected 0", num_failed); end
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL zd_error_pulses: got %0d expected 0", err_pulses - e0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_delay();
    int s;
    int v0;
    logic [7:0] msgs [3];
    msgs[0] = 8'h11; msgs[1] = 8'h22; msgs[2] = 8'h33;
    max_delay = 32'd8;
    num_msgs = 32'd3;
    load3(8'h11, 8'h22, 8'h33);
    do_reset();
    v0 = rdy_viol;
    for (int i = 0; i < 3; i++) begin
      send(msgs[i], "rd_msg", s);
      checks++; if (s > 7) begin failures++; $display("FAIL rd_stall_bound: msg %0d stalled %0d expected <=7", i, s); end
    end
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rd_done: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL rd_num_failed: got %0d expected 0", num_failed); end
    checks++; if (rdy_viol != v0) begin failures++; $display("FAIL rd_rdy_in_stall: got %0d expected 0", rdy_viol - v0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mismatch();
    int s;
    int e0;
    max_delay = 32'd0;
    num_msgs = 32'd3;
    load3(8'h11, 8'h22, 8'h33);
    do_reset();
    e0 = err_pulses;
    send(8'h11, "mm_m0", s);
    send(8'h23, "mm_m1", s);
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL mm_error_pulse: got %b expected 1", error); end
    checks++; if (num_failed !== 32'd1) begin failures++; $display("FAIL mm_num_failed_mid: got %0d expected 1", num_failed); end
    @(posedge clk);
    #1;
    send(8'h33, "mm_m2", s);
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL mm_done: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd1) begin failures++; $display("FAIL mm_num_failed: got %0d expected 1", num_failed); end
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL mm_error_count: got %0d expected 1", err_pulses - e0); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_val_drop();
    bit dropped;
    bit accepted;
    int d0;
    int wait_cnt;
    max_delay = 32'd64;
    num_msgs = 32'd12;
    for (int i = 0; i < 12; i++) dut.load_msg(4'(i), 8'(i + 64));
    do_reset();
    dropped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ifc.val = 1'b1;
      ifc.msg = 8'(i + 64);
      accepted = 1'b0;
      for (int cyc = 0; cyc < 200 && !accepted; cyc++) begin
        @(negedge clk);
        if (ifc.rdy === 1'b1) begin
          accepted = 1'b1;
          @(posedge clk);
          #1;
        end else if (!dropped && dut.state_q == c_state_delay && dut.delay_q >= 32'd6) begin
          d0 = int'(dut.delay_q);
          dropped = 1'b1;
          @(posedge clk);
          #1 ifc.val = 1'b0;
          repeat (5) @(negedge clk);
          checks++; if (dut.delay_q !== 32'(d0 - 5)) begin failures++; $display("FAIL vd_countdown: got %0d expected %0d", dut.delay_q, d0 - 5); end
          checks++; if (dut.state_q !== c_state_delay) begin failures++; $display("FAIL vd_state: got %0d expected 1", dut.state_q); end
          checks++; if (ifc.rdy !== 1'b0) begin failures++; $display("FAIL vd_rdy_low: got %b expected 0", ifc.rdy); end
          @(posedge clk);
          #1 ifc.val = 1'b1;
          wait_cnt = 0;
          while (wait_cnt < 100) begin
            @(negedge clk);
            if (ifc.rdy === 1'b1) break;
            wait_cnt++;
          end
          checks++; if (wait_cnt != d0 - 6) begin failures++; $display("FAIL vd_resume_wait: got %0d expected %0d", wait_cnt, d0 - 6); end
          accepted = (ifc.rdy === 1'b1);
          @(posedge clk);
          #1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
      if (!accepted) begin
        checks++; failures++;
        $display("FAIL vd_timeout: msg %0d not accepted, required acceptance", i);
      end
    end
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (dropped !== 1'b1) begin failures++; $display("FAIL vd_stall_seen: got %b expected 1", dropped); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL vd_done: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL vd_order: num_failed got %0d expected 0", num_failed); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int s;
    max_delay = 32'd0;
    num_msgs = 32'd3;
    load3(8'h11, 8'h22, 8'h33);
    do_reset();
    send(8'h99, "rm_bad", s);
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (num_failed !== 32'd1) begin failures++; $display("FAIL rm_pre_failed: got %0d expected 1", num_failed); end
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    checks++; if (dut.index_q !== 32'd0) begin failures++; $display("FAIL rm_index: got %0d expected 0", dut.index_q); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL rm_failed_clear: got %0d expected 0", num_failed); end
    @(posedge clk);
    #1;
    send(8'h11, "rm_m0", s);
    send(8'h22, "rm_m1", s);
    send(8'h33, "rm_m2", s);
    ifc.val = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rm_done: got %b expected 1", done); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL rm_num_failed: got %0d expected 0", num_failed); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_after_done();
    int e0;
    int rdy_hi;
    e0 = err_pulses;
    rdy_hi = 0;
    ifc.val = 1'b1;
    ifc.msg = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      if (ifc.rdy !== 1'b0) rdy_hi++;
    end
    ifc.val = 1'b0;
    checks++; if (rdy_hi != 0) begin failures++; $display("FAIL ad_rdy: high %0d cycles expected 0", rdy_hi); end
    checks++; if (num_failed !== 32'd0) begin failures++; $display("FAIL ad_num_failed: got %0d expected 0", num_failed); end
    checks++; if (err_pulses != e0) begin failures++; $display("FAIL ad_error: got %0d pulses expected 0", err_pulses - e0); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ad_done: got %b expected 1", done); end
  endtask

  initial begin
    ifc.val = 1'b0;
    ifc.msg = '0;
    test_reset();
    test_zero_delay();
    test_random_delay();
    test_mismatch();
    test_val_drop();
    test_reset_mid_run();
    test_after_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
